// File: rtl/he_pkg.sv
// Shared types and helpers for the he_stream histogram-equalisation engine.
package he_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RANK = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } he_state_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int cw_f(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/he_div.sv
// Restoring divider: one quotient bit per cycle, first step taken in the start cycle.
module he_div #(
  parameter int NW = 12,
  parameter int QW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    numerator,
  input  logic [NW-QW-1:0] denominator,
  output logic             done,
  output logic [QW-1:0]    quotient
);

  localparam int DW   = NW - QW;
  localparam int CNTW = $clog2(QW);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(QW - 1);

  logic [DW-1:0]   r_rem;
  logic [DW-1:0]   r_den;
  logic [QW-1:0]   r_low;
  logic [QW-2:0]   r_quo;
  logic [CNTW-1:0] r_cnt;
  logic            r_busy;

  logic [DW-1:0]   w_rem_in;
  logic [DW-1:0]   w_den;
  logic [QW-1:0]   w_low_in;
  logic [QW-2:0]   w_quo_in;
  logic [CNTW-1:0] w_cnt_in;
  logic [DW:0]     w_trial;
  logic            w_ge;
  logic            w_active;

  // Quotient fits in QW bits, so the upper numerator bits are already a valid remainder.
  assign w_rem_in = start ? numerator[NW-1:QW] : r_rem;
  assign w_low_in = start ? numerator[QW-1:0]  : r_low;
  assign w_den    = start ? denominator        : r_den;
  assign w_quo_in = start ? '0                 : r_quo;
  assign w_cnt_in = start ? '0                 : r_cnt;
  assign w_active = start || r_busy;

  assign w_trial  = {w_rem_in, w_low_in[QW-1]};
  assign w_ge     = (w_trial >= {1'b0, w_den});
  assign quotient = {w_quo_in, w_ge};
  assign done     = w_active && (w_cnt_in == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_active) begin
      r_busy <= !done;
      r_cnt  <= w_cnt_in + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_active) begin
      r_rem <= DW'(w_ge ? (w_trial - {1'b0, w_den}) : w_trial);
      r_low <= {w_low_in[QW-2:0], 1'b0};
      r_quo <= quotient[QW-2:0];
      r_den <= w_den;
    end
  end

endmodule

// File: rtl/he_stream.sv
// Streaming histogram equalisation: load a frame, rank every pixel, then emit
// each pixel's rounded normalised CDF in input order under back-pressure.
module he_stream
  import he_pkg::*;
#(
  parameter int N  = 8,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pixel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pixel,
  output logic          out_last
);

  localparam int CW = cw_f(N);
  localparam int IW = $clog2(N);
  localparam int NW = CW + PW;
  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [PW-1:0] PIX_MAX = '1;

  he_state_t     r_state, w_next;

  logic [PW-1:0] r_pix [N];
  logic [CW-1:0] r_cdf [N];
  logic [CW-1:0] r_cdf_min;
  logic [PW-1:0] r_min;
  logic [IW-1:0] r_k, r_j, r_o;
  logic          r_div_first;
  logic          r_out_valid, r_out_last;
  logic [PW-1:0] r_out_pixel;

  logic          w_accept, w_out_hs;
  logic          w_div_start, w_div_done;
  logic [PW-1:0] w_quo, w_pj;
  logic [CW-1:0] w_den, w_diff;
  logic [NW-1:0] w_num;

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign out_last  = r_out_last;

  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;
  assign w_pj     = r_pix[r_j];

  // Rounded normalisation: ((cdf - cdf_min) * max + D/2) / D.
  assign w_den  = CW'(N) - r_cdf_min;
  assign w_diff = r_cdf[r_o] - r_cdf_min;
  assign w_num  = ({{PW{1'b0}}, w_diff} * {{CW{1'b0}}, PIX_MAX})
                + ({{PW{1'b0}}, w_den} >> 1);

  he_div #(
    .NW(NW),
    .QW(PW)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (w_div_start),
    .numerator  (w_num),
    .denominator(w_den),
    .done       (w_div_done),
    .quotient   (w_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD:    if (w_accept && (r_k == LAST)) w_next = RANK;
      RANK:    if (r_j == LAST) w_next = DIV;
      DIV:     if (w_div_done) w_next = OUT;
      OUT:     if (w_out_hs) w_next = (r_o == LAST) ? LOAD : DIV;
      default: w_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == LOAD);
    w_div_start = (r_state == DIV) && r_div_first;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_pix[r_k] <= in_pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_j         <= '0;
      r_o         <= '0;
      r_cdf_min   <= '0;
      r_min       <= PIX_MAX;
      r_div_first <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_pixel <= '0;
      for (int i = 0; i < N; i++) r_cdf[i] <= '0;
    end else begin
      r_div_first <= (w_next == DIV) && (r_state != DIV);
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_k <= (r_k == LAST) ? '0 : r_k + IW'(1);
            if (in_pixel < r_min) r_min <= in_pixel;
          end
        end
        RANK: begin
          for (int i = 0; i < N; i++)
            r_cdf[i] <= r_cdf[i] + CW'(w_pj <= r_pix[i]);
          r_cdf_min <= r_cdf_min + CW'(w_pj <= r_min);
          r_j       <= (r_j == LAST) ? '0 : r_j + IW'(1);
        end
        DIV: begin
          if (w_div_done) begin
            // A flat frame has D=0; pass the pixel through unchanged.
            r_out_pixel <= (w_den == '0) ? r_pix[r_o] : w_quo;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_o == LAST);
          end
        end
        OUT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_o == LAST) begin
              r_o       <= '0;
              r_k       <= '0;
              r_cdf_min <= '0;
              r_min     <= PIX_MAX;
              for (int i = 0; i < N; i++) r_cdf[i] <= '0;
            end else begin
              r_o <= r_o + IW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_he_stream.sv
// Self-checking bench for he_stream: directed table, reset and random frames,
// plus a wider N=16/PW=10 instance on a ramp.
module tb_he_stream;

  localparam int N   = 8;
  localparam int PW  = 8;
  localparam int N2  = 16;
  localparam int PW2 = 10;

  typedef struct packed {
    logic [7:0][7:0] px;
    logic [7:0][7:0] ex;
    logic [1:0]      mode;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pixel = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_pixel;

  logic        in_valid2 = 1'b0;
  logic [9:0]  in_pixel2 = '0;
  logic        out_ready2 = 1'b1;
  logic        in_ready2, out_valid2, out_last2;
  logic [9:0]  out_pixel2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  he_stream #(.N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_last(out_last)
  );

  he_stream #(.N(N2), .PW(PW2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_pixel(in_pixel2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_pixel(out_pixel2), .out_last(out_last2)
  );

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: rank = count of pixels <= p, rounded scaling over the non-minimum span.
  function automatic int model_q(input int px[16], input int n, input int pw, input int o);
    int mn, cmin, c, d;
    mn = px[0];
    for (int i = 1; i < n; i++) if (px[i] < mn) mn = px[i];
    cmin = 0;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (px[i] <= mn) cmin++;
      if (px[i] <= px[o]) c++;
    end
    d = n - cmin;
    if (d == 0) return px[o];
    return ((c - cmin) * ((1 << pw) - 1) + d / 2) / d;
  endfunction

  task automatic feed(input logic [7:0][7:0] px, output int t_acc);
    int b;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_pixel = px[i];
      b = 0;
      while (!in_ready && b < 50) begin
        @(posedge clk); #1;
        b++;
      end
      check(in_ready, "feed_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    t_acc = cyc;
    in_valid = 1'b0;
  endtask

  // mode 0: ready high; 1: stall 10 cycles on pixel 3; 2: random ready and junk inputs.
  task automatic collect(input logic [7:0][7:0] ex, input int mode, input int t_acc,
                         input string name);
    int o = 0;
    int waited = 0;
    int t_hs;
    int bpc = 0;
    bit seen = 0;
    bit v, rdy;
    logic [7:0] hp;
    logic hl;
    t_hs = t_acc;
    while (o < N && waited < 3000) begin
      if (mode == 2) begin
        in_valid = 1'($urandom_range(0, 1));
        in_pixel = 8'($urandom);
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          hp = out_pixel;
          hl = out_last;
          bpc = 0;
          check(out_pixel == ex[o], {name, "_pixel"}, out_pixel, ex[o]);
          check(out_last == (o == N - 1), {name, "_last"}, out_last, o == N - 1);
          if (o == 0) check(cyc - t_acc == N + PW, {name, "_latency"}, cyc - t_acc, N + PW);
          else        check(cyc - t_hs == PW, {name, "_spacing"}, cyc - t_hs, PW);
        end else begin
          check(out_pixel == hp && out_last == hl, {name, "_hold"}, out_pixel, hp);
        end
        check(!in_ready, {name, "_in_ready_low"}, in_ready, 0);
        case (mode)
          1:       out_ready = !(o == 3 && bpc < 10);
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
        bpc++;
      end else begin
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      v = out_valid;
      rdy = out_ready;
      @(posedge clk); #1;
      waited++;
      if (v && rdy) begin
        o++;
        seen = 0;
        t_hs = cyc;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check(o == N, {name, "_complete"}, o, N);
    check(in_ready && !out_valid, {name, "_frame_end"}, in_ready, 1);
  endtask

  initial begin
    vec_t tbl[5];
    int   ramp_ex[8] = '{0, 36, 73, 109, 146, 182, 219, 255};
    int   a[16];
    int   t_acc, t_hs, w, lim;
    logic [7:0][7:0] rpx, rex;

    for (int i = 0; i < N; i++) begin
      tbl[0].px[i] = 8'(10 * (i + 1));
      tbl[0].ex[i] = 8'(ramp_ex[i]);
      tbl[1].px[i] = (i < 4) ? 8'd0 : 8'd255;
      tbl[1].ex[i] = (i < 4) ? 8'd0 : 8'd255;
      tbl[2].px[i] = 8'd5;
      tbl[2].ex[i] = 8'd5;
      tbl[3].px[i] = 8'(10 * (i + 1));
      tbl[3].ex[i] = 8'(ramp_ex[i]);
      tbl[4].px[i] = 8'(80 - 10 * i);
      tbl[4].ex[i] = 8'(ramp_ex[N - 1 - i]);
    end
    tbl[0].mode = 2'd0;
    tbl[1].mode = 2'd0;
    tbl[2].mode = 2'd0;
    tbl[3].mode = 2'd1;
    tbl[4].mode = 2'd0;

    repeat (2) @(posedge clk);
    #1;
    check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
    check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
    check(out_pixel == 8'd0, "reset_out_pixel", out_pixel, 0);
    check(out_last == 1'b0, "reset_out_last", out_last, 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      feed(tbl[t].px, t_acc);
      collect(tbl[t].ex, int'(tbl[t].mode), t_acc, $sformatf("vec%0d", t));
    end

    // Reset while ranking discards the partial frame.
    feed(tbl[0].px, t_acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check(out_valid == 1'b0, "rank_reset_out_valid", out_valid, 0);
    check(in_ready == 1'b1, "rank_reset_in_ready", in_ready, 1);
    check(out_pixel == 8'd0, "rank_reset_out_pixel", out_pixel, 0);
    rst = 1'b0;
    feed(tbl[4].px, t_acc);
    collect(tbl[4].ex, int'(tbl[4].mode), t_acc, "after_reset");

    for (int r = 0; r < 6; r++) begin
      lim = (r % 2 == 0) ? 3 : 255;
      for (int i = 0; i < 16; i++) a[i] = 0;
      for (int i = 0; i < N; i++) begin
        rpx[i] = 8'($urandom_range(0, lim));
        a[i] = int'(rpx[i]);
      end
      for (int i = 0; i < N; i++) rex[i] = 8'(model_q(a, N, PW, i));
      feed(rpx, t_acc);
      collect(rex, (r < 2) ? 0 : 2, t_acc, $sformatf("rand%0d", r));
    end

    for (int i = 0; i < N2; i++) a[i] = i * 64;
    for (int i = 0; i < N2; i++) begin
      in_valid2 = 1'b1;
      in_pixel2 = 10'(a[i]);
      check(in_ready2, "wide_in_ready", in_ready2, 1);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    t_acc = cyc;
    t_hs = t_acc;
    for (int o = 0; o < N2; o++) begin
      w = 0;
      while (!out_valid2 && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      check(out_valid2, "wide_out_valid", out_valid2, 1);
      if (o == 0) check(cyc - t_acc == N2 + PW2, "wide_latency", cyc - t_acc, N2 + PW2);
      else        check(cyc - t_hs == PW2, "wide_spacing", cyc - t_hs, PW2);
      check(int'(out_pixel2) == model_q(a, N2, PW2, o), "wide_pixel", out_pixel2,
            model_q(a, N2, PW2, o));
      check(out_last2 == (o == N2 - 1), "wide_last", out_last2, o == N2 - 1);
      @(posedge clk); #1;
      t_hs = cyc;
    end
    check(in_ready2 && !out_valid2, "wide_frame_end", in_ready2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
